// File: rtl/cond_unit_it_if.sv
// Bundle of instruction-side inputs and condition/IT status outputs for cond_unit_it.
// The master side drives the instruction stream and the slave side is the condition unit.
interface cond_unit_it_if #(
  parameter int IT_MAX_LEN = 4,
  parameter int CW         = $clog2(IT_MAX_LEN + 1)
);
  logic                  valid_i;
  logic                  stall_i;
  logic                  flush_i;
  logic [3:0]            cond_i;
  logic [3:0]            alu_flags_i;
  logic [1:0]            flag_write_i;
  logic                  it_start_i;
  logic [3:0]            it_cond_i;
  logic [CW-1:0]         it_len_i;
  logic [IT_MAX_LEN-1:0] it_pattern_i;
  logic                  cond_ex_o;
  logic                  illegal_o;
  logic [3:0]            flags_o;
  logic                  it_active_o;
  logic [CW-1:0]         it_remaining_o;

  modport master (
    output valid_i, stall_i, flush_i, cond_i, alu_flags_i, flag_write_i,
           it_start_i, it_cond_i, it_len_i, it_pattern_i,
    input  cond_ex_o, illegal_o, flags_o, it_active_o, it_remaining_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, cond_i, alu_flags_i, flag_write_i,
           it_start_i, it_cond_i, it_len_i, it_pattern_i,
    output cond_ex_o, illegal_o, flags_o, it_active_o, it_remaining_o
  );
endinterface

// File: rtl/cond_unit_it.sv
// Execute-stage condition unit: NZCV flags register, condition-code evaluation
// and sequencing of IT-style predicated blocks of up to IT_MAX_LEN instructions.
module cond_unit_it #(
  parameter int IT_MAX_LEN = 4,
  parameter int PIPE       = 0,
  parameter int CW         = $clog2(IT_MAX_LEN + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  cond_unit_it_if.slave bus
);

  localparam int IW = (IT_MAX_LEN > 1) ? $clog2(IT_MAX_LEN) : 1;

  typedef enum logic {IDLE, ACTIVE} it_state_e;

  it_state_e             state_q, state_d;
  logic [3:0]            it_cond_q, it_cond_d;
  logic [IT_MAX_LEN-1:0] pattern_q, pattern_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            flags_q;

  logic                  active;
  logic                  accept;
  logic                  is_it;
  logic [3:0]            eff_cond;
  logic [CW-1:0]         len_clamp;
  logic                  cond_ex_raw;
  logic                  illegal_raw;

  // Odd codes are the inverse of the even code below them; 1110/1111 fall out
  // of the same rule as always/never.
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    unique case (code[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = n ~^ v;
      3'd6:    base = ~z & (n ~^ v);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  assign active = (state_q == ACTIVE);
  // NOTE: reset_n gates the combinational path so every output reads 0 during reset.
  assign accept = bus.valid_i & ~bus.stall_i & reset_n;
  assign is_it  = bus.it_start_i & ~active;

  assign eff_cond = !active           ? bus.cond_i :
                    pattern_q[idx_q]  ? it_cond_q  :
                                        {it_cond_q[3:1], ~it_cond_q[0]};

  assign cond_ex_raw = accept & (is_it | eval_cond(eff_cond, flags_q));
  assign illegal_raw = accept & (active ? bus.it_start_i
                                        : (~bus.it_start_i & (bus.cond_i == 4'hF)));

  always_comb begin
    len_clamp = bus.it_len_i;
    if (bus.it_len_i == '0)
      len_clamp = CW'(1);
    else if (bus.it_len_i > CW'(IT_MAX_LEN))
      len_clamp = CW'(IT_MAX_LEN);
  end

  // NOTE: every next-state signal gets its hold value first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    it_cond_d   = it_cond_q;
    pattern_d   = pattern_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    if (bus.flush_i) begin
      state_d     = IDLE;
      remaining_d = '0;
      idx_d       = '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (bus.it_start_i) begin
            state_d     = ACTIVE;
            it_cond_d   = bus.it_cond_i;
            pattern_d   = bus.it_pattern_i | IT_MAX_LEN'(1);
            remaining_d = len_clamp;
            idx_d       = '0;
          end
        end
        ACTIVE: begin
          remaining_d = remaining_q - 1'b1;
          idx_d       = idx_q + 1'b1;
          if (remaining_q == CW'(1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      it_cond_q   <= '0;
      pattern_q   <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      it_cond_q   <= it_cond_d;
      pattern_q   <= pattern_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
    end
  end

  // The IT instruction itself never writes flags; flush leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (cond_ex_raw & ~is_it) begin
      if (bus.flag_write_i[1]) flags_q[3:2] <= bus.alu_flags_i[3:2];
      if (bus.flag_write_i[0]) flags_q[1:0] <= bus.alu_flags_i[1:0];
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic cond_ex_q, illegal_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cond_ex_q <= 1'b0;
        illegal_q <= 1'b0;
      end else begin
        cond_ex_q <= cond_ex_raw;
        illegal_q <= illegal_raw;
      end
    end
    assign bus.cond_ex_o = cond_ex_q;
    assign bus.illegal_o = illegal_q;
  end else begin : g_comb
    assign bus.cond_ex_o = cond_ex_raw;
    assign bus.illegal_o = illegal_raw;
  end

  assign bus.flags_o        = flags_q;
  assign bus.it_active_o    = active;
  assign bus.it_remaining_o = remaining_q;

endmodule

// File: tb/tb_cond_unit_it.sv
// Scoreboard bench for cond_unit_it: PIPE=0 and PIPE=1 instances share one
// instruction stream and are checked against a list-based behavioural model.
module tb_cond_unit_it;
  localparam int ITM = 4;
  localparam int CW  = $clog2(ITM + 1);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cond_unit_it_if #(.IT_MAX_LEN(ITM)) bus0 ();
  cond_unit_it_if #(.IT_MAX_LEN(ITM)) bus1 ();

  assign bus1.valid_i      = bus0.valid_i;
  assign bus1.stall_i      = bus0.stall_i;
  assign bus1.flush_i      = bus0.flush_i;
  assign bus1.cond_i       = bus0.cond_i;
  assign bus1.alu_flags_i  = bus0.alu_flags_i;
  assign bus1.flag_write_i = bus0.flag_write_i;
  assign bus1.it_start_i   = bus0.it_start_i;
  assign bus1.it_cond_i    = bus0.it_cond_i;
  assign bus1.it_len_i     = bus0.it_len_i;
  assign bus1.it_pattern_i = bus0.it_pattern_i;

  cond_unit_it #(.IT_MAX_LEN(ITM), .PIPE(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  cond_unit_it #(.IT_MAX_LEN(ITM), .PIPE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  typedef struct {
    logic       ex;
    logic       ill;
    logic [3:0] flags;
    logic       active;
    int         rem;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] it_list[$];
  logic [3:0] m_flags;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return c && !z;
      4'd9:    return !(c && !z);
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return !(!z && (n == v));
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected response for the instruction now on the inputs, then advance the model.
  task automatic model_step();
    exp_t e;
    logic acc, act, it_instr;
    logic [3:0] eff;
    int len;
    acc      = bus0.valid_i && !bus0.stall_i;
    act      = it_list.size() > 0;
    eff      = act ? it_list[0] : bus0.cond_i;
    it_instr = bus0.it_start_i && !act;
    e.ex     = acc && (it_instr || cond_holds(eff, m_flags));
    e.ill    = acc && (act ? bus0.it_start_i : (!bus0.it_start_i && bus0.cond_i == 4'hF));
    e.flags  = m_flags;
    e.active = act;
    e.rem    = it_list.size();
    sbq.push_back(e);
    if (e.ex && !it_instr) begin
      if (bus0.flag_write_i[1]) m_flags[3:2] = bus0.alu_flags_i[3:2];
      if (bus0.flag_write_i[0]) m_flags[1:0] = bus0.alu_flags_i[1:0];
    end
    if (bus0.flush_i) begin
      it_list.delete();
    end else if (acc) begin
      if (act) begin
        void'(it_list.pop_front());
      end else if (bus0.it_start_i) begin
        len = int'(bus0.it_len_i);
        if (len < 1) len = 1;
        if (len > ITM) len = ITM;
        for (int k = 0; k < len; k++)
          it_list.push_back((k == 0 || bus0.it_pattern_i[k]) ? bus0.it_cond_i
                                                             : {bus0.it_cond_i[3:1], ~bus0.it_cond_i[0]});
      end
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [1:0] fw, input logic its,
                       input logic [3:0] itc, input logic [CW-1:0] itl, input logic [ITM-1:0] itp);
    @(posedge clk);
    #1;
    bus0.valid_i      = v;
    bus0.stall_i      = st;
    bus0.flush_i      = fl;
    bus0.cond_i       = cond;
    bus0.alu_flags_i  = alu;
    bus0.flag_write_i = fw;
    bus0.it_start_i   = its;
    bus0.it_cond_i    = itc;
    bus0.it_len_i     = itl;
    bus0.it_pattern_i = itp;
    model_step();
  endtask

  task automatic instr(input logic [3:0] cond);
    drive(1, 0, 0, cond, 4'h0, 2'b00, 0, 4'h0, '0, '0);
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1, 0, 0, 4'hE, f, 2'b11, 0, 4'h0, '0, '0);
  endtask

  task automatic it_start(input logic [3:0] c, input logic [CW-1:0] len, input logic [ITM-1:0] pat);
    drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 1, c, len, pat);
  endtask

  task automatic idle_inputs();
    bus0.valid_i = 0; bus0.stall_i = 0; bus0.flush_i = 0; bus0.cond_i = 0;
    bus0.alu_flags_i = 0; bus0.flag_write_i = 0; bus0.it_start_i = 0;
    bus0.it_cond_i = 0; bus0.it_len_i = '0; bus0.it_pattern_i = '0;
  endtask

  // Asynchronous reset mid-cycle with an instruction still presented.
  task automatic reset_mid_block();
    @(posedge clk);
    #1;
    bus0.valid_i = 1;
    bus0.cond_i  = 4'hE;
    reset_n      = 0;
    #1;
    check("rst_ex0",  bus0.cond_ex_o,      0);
    check("rst_ex1",  bus1.cond_ex_o,      0);
    check("rst_ill0", bus0.illegal_o,      0);
    check("rst_act1", bus1.it_active_o,    0);
    check("rst_rem1", bus1.it_remaining_o, 0);
    check("rst_flg1", bus1.flags_o,        0);
    m_flags = '0;
    it_list.delete();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  // Monitor: every presented cycle pops one expectation; PIPE=1 lags by one entry.
  initial begin
    exp_t e, prev;
    prev = '{ex: 0, ill: 0, flags: 0, active: 0, rem: 0};
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        prev = '{ex: 0, ill: 0, flags: 0, active: 0, rem: 0};
      end else begin
        e = sbq.pop_front();
        check("cond_ex0",    bus0.cond_ex_o,      e.ex);
        check("illegal0",    bus0.illegal_o,      e.ill);
        check("flags0",      bus0.flags_o,        e.flags);
        check("it_active0",  bus0.it_active_o,    e.active);
        check("it_rem0",     bus0.it_remaining_o, e.rem);
        check("cond_ex1",    bus1.cond_ex_o,      prev.ex);
        check("illegal1",    bus1.illegal_o,      prev.ill);
        check("flags1",      bus1.flags_o,        e.flags);
        check("it_rem1",     bus1.it_remaining_o, e.rem);
        prev = e;
      end
    end
  end

  initial begin
    logic [3:0] fvals[6];
    fvals = '{4'b0000, 4'b1000, 4'b1001, 4'b0100, 4'b0010, 4'b1101};
    m_flags = '0;
    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;

    // Split field writes, then all 16 codes under several flag values.
    drive(1, 0, 0, 4'hE, 4'b1001, 2'b10, 0, 4'h0, '0, '0);
    drive(1, 0, 0, 4'hE, 4'b1001, 2'b01, 0, 4'h0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      set_flags(fvals[i]);
      for (int c = 0; c < 16; c++) instr(4'(c));
    end

    // EQ block, len 3, pattern 101 with Z=1.
    set_flags(4'b0100);
    it_start(4'h0, 3, 4'b0101);
    for (int i = 0; i < 4; i++) instr(4'hF);

    // Stall inside an active block, base 1110 so inverse slots evaluate never.
    it_start(4'hE, 4, 4'b0011);
    instr(4'h3);
    drive(1, 1, 0, 4'h3, 4'h0, 2'b00, 0, 4'h0, '0, '0);
    drive(1, 1, 0, 4'h3, 4'h0, 2'b00, 0, 4'h0, '0, '0);
    for (int i = 0; i < 4; i++) instr(4'h3);

    // Flush on the second instruction, then nested IT start, then clamped lengths.
    it_start(4'hA, 4, 4'b1010);
    instr(4'h0);
    drive(1, 0, 1, 4'h0, 4'h0, 2'b00, 0, 4'h0, '0, '0);
    instr(4'h1);
    it_start(4'h1, 4, 4'b0000);
    instr(4'h0);
    drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 1, 4'h0, 1, 4'b1111);
    for (int i = 0; i < 3; i++) instr(4'hE);
    it_start(4'h0, 0, 4'b0000);
    instr(4'hE); instr(4'hE);
    it_start(4'h1, 7, 4'b0110);
    for (int i = 0; i < 6; i++) instr(4'hE);

    // Reset asserted mid-block.
    it_start(4'h0, 4, 4'b1111);
    instr(4'h0);
    reset_mid_block();
    instr(4'hF);
    instr(4'h0);

    for (int i = 0; i < 2500; i++) begin
      logic its;
      its = ($urandom_range(0, 99) < 15);
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
            4'($urandom), 4'($urandom), 2'($urandom), its, 4'($urandom),
            CW'($urandom_range(0, 7)), ITM'($urandom));
    end

    drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 4'h0, '0, '0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_unit_it.md
# cond_unit_it

Parametrised condition unit for the processor's execute stage. It holds the architectural NZCV flags register and applies per-field flag writes. It evaluates the 4-bit condition code of each instruction and sequences IT-style predicated blocks of up to IT_MAX_LEN instructions, driving the execute-enable to the register-file and memory write gating. Compared with the earlier purely combinational condition check, this block adds:

- registered flags;
- a correct GE/LT/GT/LE (N == V);
- a defined never/illegal code;
- an optional registered output.

## Interface
Parameters:
- IT_MAX_LEN, 4, maximum instructions covered by one IT block (1..8)
- PIPE, 0, 0 = cond_ex_o/illegal_o combinational; 1 = registered, one cycle later
- CW, $clog2(IT_MAX_LEN+1), width of length/remaining counters (derived, do not override)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- valid_i  in  1  an instruction occupies the stage this cycle
- stall_i  in  1  stage stalled; no state changes
- flush_i  in  1  pipeline flush; cancels any IT block
- cond_i  in  4  instruction condition field
- alu_flags_i  in  4  {N,Z,C,V} from the ALU for the current instruction
- flag_write_i  in  2  bit1 updates N,Z; bit0 updates C,V
- it_start_i  in  1  current instruction is an IT instruction
- it_cond_i  in  4  IT base condition
- it_len_i  in  CW  instructions in the block, 1..IT_MAX_LEN
- it_pattern_i  in  IT_MAX_LEN  bit k: 1 = k-th instruction uses base condition, 0 = inverse
- cond_ex_o  out  1  execute enable
- illegal_o  out  1  illegal condition or nested IT start
- flags_o  out  4  current registered {N,Z,C,V}
- it_active_o  out  1  IT block in progress
- it_remaining_o  out  CW  instructions left in the block

## Operation
Condition decode uses flags_q (the registered flags). For codes 0000..1101, the meaning is as follows:
- EQ, NE: Z, ~Z.
- CS, CC: C, ~C.
- MI, PL: N, ~N.
- VS, VC: V, ~V.
- HI, LS: C&~Z, and its inverse.
- GE, LT: N==V, N!=V.
- GT, LE: ~Z&(N==V), and its inverse.
- 1110: always.
- 1111: never, and illegal when it comes from cond_i outside an IT block.

Effective condition:
- IT idle: cond_i.
- IT active: it_cond_q when pattern bit [idx] = 1; otherwise it_cond_q with bit 0 inverted.
  - Inverse of 1110 yields 1111, which evaluates to never and is not illegal.
  - cond_i is ignored while active.

Raw outputs:
- cond_ex = valid_i & ~stall_i & eval(effective condition).
- An IT instruction itself always executes (cond_ex = 1) and never writes flags.

Flags:
- On a clock edge with valid_i & ~stall_i & cond_ex, fields selected by flag_write_i load from alu_flags_i.
- Unselected fields hold.
- flush_i does not affect flags.

IT state machine, states IDLE and ACTIVE:
- IDLE -> ACTIVE on valid_i & ~stall_i & ~flush_i & it_start_i.
  - Loads it_cond_i, it_pattern_i, and remaining = it_len_i, idx = 0.
  - it_len_i = 0 is clamped to 1; values above IT_MAX_LEN are clamped to IT_MAX_LEN.
  - Bit 0 of the pattern is forced to 1.
- ACTIVE: each valid_i & ~stall_i instruction (executed or not) increments idx and decrements remaining.
  - Transition to IDLE when remaining reaches 0.
- it_start_i while ACTIVE: treated as a normal predicated instruction; illegal_o = 1 and no reload.
- flush_i (any state, stall irrelevant): next state IDLE, remaining 0. flush_i has priority over load and advance.
- Reset: IDLE, flags 0000, remaining 0, idx 0, registered outputs 0.

## Timing
- PIPE=0: cond_ex_o and illegal_o are combinational from inputs and state, and are 0 when valid_i=0 or stall_i=1.
- PIPE=1: both are registered and appear one cycle after the instruction. The register captures 0 while stalled.
- A flag update becomes visible to the very next instruction; there is no same-cycle forwarding.
- it_active_o and it_remaining_o are registered. They go high / load on the cycle after the IT instruction is accepted.
- The instruction after the IT instruction is the first predicated one.
- Reset assertion mid-block aborts immediately and asynchronously. All outputs go to 0 while reset_n = 0.

## Test plan
- Reset then eval all 16 codes with flags_q forced via writes, e.g. N=1,V=0 -> GE=0, LT=1; N=1,V=1,Z=0 -> GT=1; cond 1111 -> cond_ex_o=0, illegal_o=1.
- Write flags {1,0,0,1} with flag_write_i=2'b10 from state 0000 -> flags_o=1000; next cycle write 2'b01 -> flags_o=1001.
- IT with base EQ, len 3, pattern 3'b101, Z=1, three instructions -> cond_ex_o 1,0,1; it_remaining_o 3,2,1,0; then IDLE.
- Stall during ACTIVE for 2 cycles -> it_remaining_o unchanged, cond_ex_o=0; advance resumes after stall.
- flush_i on the second instruction of a len-4 block -> it_active_o=0 next cycle, the following instruction uses its own cond_i; nested it_start_i -> illegal_o=1, no reload.
- PIPE=1: same IT sequence -> identical cond_ex_o values delayed exactly one cycle; reset_n low mid-block -> all outputs 0 immediately.
